// File: rtl/ra_bist_pkg.sv
// Shared constants, march-element helpers and FSM encoding for the 64x72 2R1W BIST controller.
package ra_bist_pkg;

    localparam int ADR_W = 6;
    localparam int DAT_W = 72;
    localparam int WORDS = 64;

    typedef enum logic [2:0] {M0 = 3'd0, M1, M2, M3, M4, M5} elem_e;

    typedef enum logic [2:0] {S_IDLE, S_M0, S_RD, S_WR, S_DRAIN, S_DONE} state_e;

    // M3..M5 walk the address space top-down.
    function automatic logic elem_down(elem_e e);
        return e inside {M3, M4, M5};
    endfunction

    // Read expects the inverted background in M2 and M4.
    function automatic logic rd_inv(elem_e e);
        return e inside {M2, M4};
    endfunction

    // Write data is the inverted background in M1 and M3.
    function automatic logic wr_inv(elem_e e);
        return e inside {M1, M3};
    endfunction

    function automatic logic [DAT_W-1:0] bg_sel(logic inv, logic [DAT_W-1:0] bg);
        return inv ? ~bg : bg;
    endfunction

endpackage

// File: rtl/ra_bist_ctl_2r1w_64x72_cmp_pipe.sv
// Read-latency expect pipeline with dual-port compare and first-failure capture.
module ra_bist_cmp_pipe
    import ra_bist_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [DAT_W-1:0] exp_i,
    input  logic [ADR_W-1:0] adr_i,
    input  logic [2:0]       elem_i,
    input  logic [DAT_W-1:0] rd_dat_0_i,
    input  logic [DAT_W-1:0] rd_dat_1_i,
    output logic             fail_o,
    output logic [ADR_W-1:0] fail_adr_o,
    output logic [2:0]       fail_elem_o,
    output logic [1:0]       fail_port_o
);

    logic [RD_LAT-1:0] vld_q;
    logic [DAT_W-1:0]  exp_q  [RD_LAT];
    logic [ADR_W-1:0]  adr_q  [RD_LAT];
    logic [2:0]        elem_q [RD_LAT];

    logic             fail_q;
    logic [ADR_W-1:0] fail_adr_q;
    logic [2:0]       fail_elem_q;
    logic [1:0]       fail_port_q;
    logic [1:0]       mis;

    // The oldest entry lines up with the returning read data.
    assign mis = {vld_q[RD_LAT-1] && (rd_dat_0_i != exp_q[RD_LAT-1]),
                  vld_q[RD_LAT-1] && (rd_dat_1_i != exp_q[RD_LAT-1])};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                exp_q[k]  <= '0;
                adr_q[k]  <= '0;
                elem_q[k] <= '0;
            end
        end else begin
            vld_q[0]  <= push_i;
            exp_q[0]  <= exp_i;
            adr_q[0]  <= adr_i;
            elem_q[0] <= elem_i;
            for (int k = 1; k < RD_LAT; k++) begin
                vld_q[k]  <= vld_q[k-1];
                exp_q[k]  <= exp_q[k-1];
                adr_q[k]  <= adr_q[k-1];
                elem_q[k] <= elem_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fail_q      <= 1'b0;
            fail_adr_q  <= '0;
            fail_elem_q <= '0;
            fail_port_q <= '0;
        end else if (clr_i) begin
            fail_q      <= 1'b0;
            fail_adr_q  <= '0;
            fail_elem_q <= '0;
            fail_port_q <= '0;
        end else if (mis != 2'b00) begin
            fail_q <= 1'b1;
            if (!fail_q) begin
                fail_adr_q  <= adr_q[RD_LAT-1];
                fail_elem_q <= elem_q[RD_LAT-1];
                fail_port_q <= mis;
            end
        end
    end

    assign fail_o      = fail_q;
    assign fail_adr_o  = fail_adr_q;
    assign fail_elem_o = fail_elem_q;
    assign fail_port_o = fail_port_q;

endmodule

// File: rtl/ra_bist_ctl_2r1w_64x72.sv
// March C- BIST sequencer driving the 64x72 2R1W array ports; outputs are all flops.
module ra_bist_ctl_2r1w_64x72
    import ra_bist_pkg::*;
#(
    parameter int               RD_LAT  = 2,
    parameter logic [DAT_W-1:0] DATA_BG = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             bist_start,
    output logic             bist_busy,
    output logic             bist_done,
    output logic             bist_fail,
    output logic [ADR_W-1:0] fail_adr,
    output logic [2:0]       fail_elem,
    output logic [1:0]       fail_port,
    output logic             rd_enb_0,
    output logic [ADR_W-1:0] rd_adr_0,
    input  logic [DAT_W-1:0] rd_dat_0,
    output logic             rd_enb_1,
    output logic [ADR_W-1:0] rd_adr_1,
    input  logic [DAT_W-1:0] rd_dat_1,
    output logic             wr_enb_0,
    output logic [ADR_W-1:0] wr_adr_0,
    output logic [DAT_W-1:0] wr_dat_0
);

    localparam logic [ADR_W-1:0] ADR_MAX = ADR_W'(WORDS - 1);

    state_e           state_q, state_d;
    elem_e            elem_q, elem_d, nelem;
    logic [ADR_W-1:0] adr_q, adr_d, nadr;
    logic [1:0]       dcnt_q, dcnt_d;
    logic             last, start_acc, wr_go, rd_go;

    logic             busy_q, done_q, rd_enb_q, wr_enb_q;
    logic [ADR_W-1:0] rd_adr_q, wr_adr_q;
    logic [DAT_W-1:0] wr_dat_q;

    // state/elem/adr always describe the operation currently on the ports.
    always_comb begin
        state_d   = state_q;
        elem_d    = elem_q;
        adr_d     = adr_q;
        dcnt_d    = dcnt_q;
        start_acc = 1'b0;
        last      = elem_down(elem_q) ? (adr_q == '0) : (adr_q == ADR_MAX);
        nadr      = elem_down(elem_q) ? adr_q - ADR_W'(1) : adr_q + ADR_W'(1);
        nelem     = elem_e'(elem_q + 3'd1);
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bist_start) begin
                    start_acc = 1'b1;
                    state_d   = S_M0;
                    elem_d    = M0;
                    adr_d     = '0;
                end
            end
            S_M0: begin
                if (last) begin
                    state_d = S_RD;
                    elem_d  = M1;
                    adr_d   = '0;
                end else begin
                    adr_d = nadr;
                end
            end
            S_RD: begin
                if (elem_q != M5) begin
                    state_d = S_WR;
                end else if (last) begin
                    state_d = S_DRAIN;
                    dcnt_d  = '0;
                end else begin
                    adr_d = nadr;
                end
            end
            S_WR: begin
                state_d = S_RD;
                if (last) begin
                    elem_d = nelem;
                    adr_d  = elem_down(nelem) ? ADR_MAX : '0;
                end else begin
                    adr_d = nadr;
                end
            end
            S_DRAIN: begin
                if (dcnt_q == 2'(RD_LAT - 1)) state_d = S_DONE;
                else                          dcnt_d  = dcnt_q + 2'd1;
            end
            default: state_d = S_IDLE;
        endcase
        wr_go = state_d inside {S_M0, S_WR};
        rd_go = (state_d == S_RD);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            elem_q   <= M0;
            adr_q    <= '0;
            dcnt_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_enb_q <= 1'b0;
            rd_adr_q <= '0;
            wr_enb_q <= 1'b0;
            wr_adr_q <= '0;
            wr_dat_q <= '0;
        end else begin
            state_q  <= state_d;
            elem_q   <= elem_d;
            adr_q    <= adr_d;
            dcnt_q   <= dcnt_d;
            busy_q   <= state_d inside {S_M0, S_RD, S_WR, S_DRAIN};
            done_q   <= (state_d == S_DONE);
            rd_enb_q <= rd_go;
            rd_adr_q <= rd_go ? adr_d : '0;
            wr_enb_q <= wr_go;
            wr_adr_q <= wr_go ? adr_d : '0;
            wr_dat_q <= wr_go ? bg_sel(wr_inv(elem_d), DATA_BG) : '0;
        end
    end

    ra_bist_cmp_pipe #(.RD_LAT(RD_LAT)) u_cmp (
        .clk         (clk),
        .reset_n     (reset_n),
        .clr_i       (start_acc),
        .push_i      (rd_enb_q),
        .exp_i       (bg_sel(rd_inv(elem_q), DATA_BG)),
        .adr_i       (rd_adr_q),
        .elem_i      (elem_q),
        .rd_dat_0_i  (rd_dat_0),
        .rd_dat_1_i  (rd_dat_1),
        .fail_o      (bist_fail),
        .fail_adr_o  (fail_adr),
        .fail_elem_o (fail_elem),
        .fail_port_o (fail_port)
    );

    assign bist_busy = busy_q;
    assign bist_done = done_q;
    assign rd_enb_0  = rd_enb_q;
    assign rd_enb_1  = rd_enb_q;
    assign rd_adr_0  = rd_adr_q;
    assign rd_adr_1  = rd_adr_q;
    assign wr_enb_0  = wr_enb_q;
    assign wr_adr_0  = wr_adr_q;
    assign wr_dat_0  = wr_dat_q;

endmodule
